// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: multi-digit packed-BCD up/down counter stepped by the
// rising edge of a divided tick sampled in the clk domain. Emits a one-cycle
// wrap pulse on rollover (all 9s -> all 0s) and rollunder (all 0s -> all 9s).
// Optional build macro: TICK_SYNC_EN inserts a two-flop synchronizer (reset
// to 1) in front of the edge detector, adding two cycles of step latency.
module bcd_tick_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tickIn,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   loadValue,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap
);

    localparam int W = 4 * DIGITS;

    logic           tick_s;
    logic           tick_prev_reg;
    logic           step;
    logic [W-1:0]   count_reg;
    logic [W-1:0]   count_next;
    logic           wrap_reg;
    logic           wrap_next;
    logic [W-1:0]   load_clamped;
    logic [W-1:0]   inc_value;
    logic [W-1:0]   dec_value;
    logic           inc_carry;
    logic           dec_borrow;

`ifdef TICK_SYNC_EN
    logic [1:0] sync_reg;

    // Two-flop synchronizer; resets high so a tick already high at release is not an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], tickIn};
        end
    end

    assign tick_s = sync_reg[1];
`else
    assign tick_s = tickIn;
`endif

    // Previous-tick register for rising-edge detection; keeps tracking even while disabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_prev_reg <= 1'b1;
        end else begin
            tick_prev_reg <= tick_s;
        end
    end

    assign step = tick_s & ~tick_prev_reg & enable;

    // Per-digit clamp of the load value so the counter never holds a non-BCD digit
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_clamp
            assign load_clamped[4*gi +: 4] =
                (loadValue[4*gi +: 4] > 4'd9) ? 4'd9 : loadValue[4*gi +: 4];
        end
    endgenerate

    // Ripple-carry BCD increment, digit 0 first; carry out of the top digit is the rollover
    always_comb begin
        logic carry;
        carry     = 1'b1;
        inc_value = count_reg;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_reg[4*i +: 4] >= 4'd9) begin
                    inc_value[4*i +: 4] = 4'd0;
                end else begin
                    inc_value[4*i +: 4] = count_reg[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        inc_carry = carry;
    end

    // Ripple-borrow BCD decrement; borrow out of the top digit is the rollunder
    always_comb begin
        logic borrow;
        borrow    = 1'b1;
        dec_value = count_reg;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count_reg[4*i +: 4] == 4'd0) begin
                    dec_value[4*i +: 4] = 4'd9;
                end else begin
                    dec_value[4*i +: 4] = count_reg[4*i +: 4] - 4'd1;
                    borrow              = 1'b0;
                end
            end
        end
        dec_borrow = borrow;
    end

    // Next-state select: load beats step (a coincident edge is consumed), otherwise hold
    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = load_clamped;
        end else if (step) begin
            if (up) begin
                count_next = inc_value;
                wrap_next  = inc_carry;
            end else begin
                count_next = dec_value;
                wrap_next  = dec_borrow;
            end
        end
    end

    // Registered count and wrap pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign count = count_reg;
    assign wrap  = wrap_reg;

endmodule

// File: doc/bcd_tick_counter.md
# bcd_tick_counter

Multi-digit BCD up/down counter advanced by the divided tick produced by the clock divider stage. It sits directly downstream of the divider. It samples the divider's `outClk` as an ordinary signal in the `clk` domain and advances one count per rising edge of that signal. It drives the display/readout logic with packed BCD digits and a wrap pulse.

## Interface
Parameters:
- `DIGITS`, default 4: number of BCD digits; legal range 1..8.

Ports:
- `clk`, input, 1: system clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low; 0 = reset.
- `tickIn`, input, 1: divider output; a 0→1 transition requests one step.
- `enable`, input, 1: 1 = steps allowed; 0 = tick edges discarded.
- `up`, input, 1: 1 = increment; 0 = decrement; sampled on the same edge as the step.
- `load`, input, 1: synchronous load of `loadValue`.
- `loadValue`, input, 4*DIGITS: packed BCD; digit 0 = bits [3:0].
- `count`, output, 4*DIGITS: registered packed BCD count.
- `wrap`, output, 1: one-cycle pulse on rollover/rollunder.

## Operation
- Edge detect: `tickPrev` register holds the previous sampled tick. A step is requested when `tickS & ~tickPrev`, where `tickS` is `tickIn`, or its synchronized copy (see Configuration).
- Priority per cycle:
  - load, then step, then hold.
  - Load with a simultaneous tick edge: load wins; that edge is consumed and not replayed.
- Load: each 4-bit digit >9 is clamped to 9. `wrap` = 0.
- Step up: ripple-carry BCD increment, digit 0 first.
  - A digit at 9 becomes 0 and carries into the next digit.
  - All digits 9 → all 0, `wrap` = 1 for that cycle.
- Step down: BCD decrement with borrow.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - All digits 0 → all 9, `wrap` = 1.
- `enable` = 0: no step, but `tickPrev` keeps tracking. Re-enabling while `tickIn` is held high does not generate a step.
- `up` changing between steps is legal; each step uses `up` on its own edge.
- Counter state is never non-BCD. Every reachable `count` digit is 0..9.

## Timing
- Reset (asynchronous assert, release on any edge):
  - `count` = 0, `wrap` = 0.
  - `tickPrev` = 1, so `tickIn` already high at release does not step.
  - Synchronizer flops (if present) = 1.
- Without sync: `tickIn` first seen high at `clk` edge k → `count`/`wrap` updated at edge k (visible after k).
- With sync: same update at edge k+2.
- `wrap` is high exactly one cycle per rollover. Back-to-back rollovers (DIGITS=1, tick every 2 cycles) give separate pulses.
- Minimum tick spacing: `tickIn` high ≥1 cycle and low ≥1 cycle. Every such edge steps exactly once.
- Load latency: `load` high at edge k → `count` = clamped `loadValue` after edge k.
- Reset asserted mid-count clears immediately (asynchronous). It is not deferred to the next edge.

## Configuration
- `TICK_SYNC_EN` defined: `tickIn` passes through a two-flop synchronizer (reset to 1) before edge detection. This adds 2 cycles of latency and is used when the tick source is not `clk`-registered.
- `TICK_SYNC_EN` not defined: `tickIn` feeds the edge detector directly. The source must be registered on `clk`, as the divider output is.
- All other behaviour is identical in both builds.

## Test plan
- Reset release with `tickIn` held 1, `enable`=1 → `count` stays 0000, no `wrap`. First 0→1 after that → `count`=0001.
- DIGITS=4, `up`=1, load 9999 then one tick → `count`=0000, `wrap`=1 for exactly one cycle. Load 0199 then tick → 0200.
- `up`=0: load 0000 then tick → 9999 with `wrap` pulse. Load 1000 then tick → 0999.
- `load`=1 with a simultaneous tick edge, `loadValue`=0x12F4 → `count`=0x1294, no extra step. The next tick gives 1295 (up).
- `enable`=0 for 5 tick edges, then `enable`=1 with `tickIn` high → no change. The next rising edge steps once.
- Reset pulsed low mid-cycle between `clk` edges → `count`=0 and `wrap`=0 before the next edge. Under `TICK_SYNC_EN`, the step lands 2 cycles after `tickIn` rises.
